// File: rtl/periph_io_controller.sv
// Memory-mapped board I/O block: synchronised/debounced inputs, LED and
// 7-segment display registers, and a one-cycle-latency load/store port.
module periph_io_controller #(
    parameter logic [31:0] BASE_ADDR       = 32'hC000_0000,
    parameter int unsigned DEBOUNCE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        irq,
    input  logic [9:0]  switches,
    input  logic        button,
    output logic [9:0]  leds,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    localparam logic [16:0] DB_LIMIT = 17'(DEBOUNCE_CYCLES);

    logic        sel;
    logic [3:0]  idx;
    logic        wr;
    logic        rd;

    logic [9:0]  led_reg;
    logic [1:0]  ctrl_reg;
    logic [23:0] hexval_reg;
    logic [6:0]  seg_reg [6];
    logic        event_reg, event_next;
    logic        level_reg, level_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [9:0]  sw_sync1_reg, sw_sync2_reg;
    logic        btn_sync1_reg, btn_sync2_reg;
    logic [31:0] rdata_reg;
    logic        rvalid_reg;
    logic        irq_reg;
    logic [9:0]  leds_reg;
    logic [31:0] rd_val;
    logic [6:0]  hex_q [6];
    logic        unused_bits;

    assign sel = (addr[31:6] == BASE_ADDR[31:6]);
    assign idx = addr[5:2];
    assign wr  = we & sel;
    assign rd  = re & sel;
    assign unused_bits = ^{addr[1:0], wdata[31:24]};

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'h3F;
            4'h1: seg_decode = 7'h06;
            4'h2: seg_decode = 7'h5B;
            4'h3: seg_decode = 7'h4F;
            4'h4: seg_decode = 7'h66;
            4'h5: seg_decode = 7'h6D;
            4'h6: seg_decode = 7'h7D;
            4'h7: seg_decode = 7'h07;
            4'h8: seg_decode = 7'h7F;
            4'h9: seg_decode = 7'h6F;
            4'hA: seg_decode = 7'h77;
            4'hB: seg_decode = 7'h7C;
            4'hC: seg_decode = 7'h39;
            4'hD: seg_decode = 7'h5E;
            4'hE: seg_decode = 7'h79;
            default: seg_decode = 7'h71;
        endcase
    endfunction

    // Debounce: a differing level must persist DEBOUNCE_CYCLES samples to be accepted.
    always_comb begin
        level_next = level_reg;
        cnt_next   = '0;
        if (btn_sync2_reg != level_reg) begin
            if ({1'b0, cnt_reg} + 17'd1 >= DB_LIMIT) begin
                level_next = ~level_reg;
            end else begin
                cnt_next = cnt_reg + 16'd1;
            end
        end
    end

    // A new press beats a simultaneous write-one-to-clear.
    always_comb begin
        event_next = event_reg;
        if (wr && idx == 4'd2 && wdata[1]) begin
            event_next = 1'b0;
        end
        if (level_next && !level_reg) begin
            event_next = 1'b1;
        end
    end

    always_comb begin
        rd_val = '0;
        case (idx)
            4'd0:    rd_val = {22'd0, led_reg};
            4'd1:    rd_val = {22'd0, sw_sync2_reg};
            4'd2:    rd_val = {30'd0, event_reg, level_reg};
            4'd3:    rd_val = {30'd0, ctrl_reg};
            4'd4:    rd_val = {8'd0, hexval_reg};
            default: rd_val = '0;
        endcase
        for (int i = 0; i < 6; i++) begin
            if (idx == 4'(i + 5)) begin
                rd_val = {25'd0, seg_reg[i]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_reg       <= '0;
            ctrl_reg      <= '0;
            hexval_reg    <= '0;
            for (int i = 0; i < 6; i++) begin
                seg_reg[i] <= 7'h7F;
            end
            event_reg     <= 1'b0;
            level_reg     <= 1'b0;
            cnt_reg       <= '0;
            sw_sync1_reg  <= '0;
            sw_sync2_reg  <= '0;
            btn_sync1_reg <= 1'b0;
            btn_sync2_reg <= 1'b0;
            rdata_reg     <= '0;
            rvalid_reg    <= 1'b0;
            irq_reg       <= 1'b0;
            leds_reg      <= '0;
        end else begin
            sw_sync1_reg  <= switches;
            sw_sync2_reg  <= sw_sync1_reg;
            btn_sync1_reg <= button;
            btn_sync2_reg <= btn_sync1_reg;
            level_reg     <= level_next;
            cnt_reg       <= cnt_next;
            event_reg     <= event_next;
            if (wr) begin
                case (idx)
                    4'd0:    led_reg    <= wdata[9:0];
                    4'd3:    ctrl_reg   <= wdata[1:0];
                    4'd4:    hexval_reg <= wdata[23:0];
                    default: ;
                endcase
                for (int i = 0; i < 6; i++) begin
                    if (idx == 4'(i + 5)) begin
                        seg_reg[i] <= wdata[6:0];
                    end
                end
            end
            // rd_val is taken from pre-store state, so a same-cycle store is not visible.
            if (rd) begin
                rdata_reg <= rd_val;
            end
            rvalid_reg <= rd;
            irq_reg    <= ctrl_reg[0] & event_reg;
            leds_reg   <= led_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_hex
            logic [6:0] hex_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hex_reg <= 7'h7F;
                end else if (ctrl_reg[1]) begin
                    hex_reg <= ~seg_decode(hexval_reg[4*gi +: 4]);
                end else begin
                    hex_reg <= seg_reg[gi];
                end
            end
            assign hex_q[gi] = hex_reg;
        end
    endgenerate

    assign rdata  = rdata_reg;
    assign rvalid = rvalid_reg;
    assign irq    = irq_reg;
    assign leds   = leds_reg;
    assign hex0   = hex_q[0];
    assign hex1   = hex_q[1];
    assign hex2   = hex_q[2];
    assign hex3   = hex_q[3];
    assign hex4   = hex_q[4];
    assign hex5   = hex_q[5];

endmodule

// File: tb/tb_periph_io_controller.sv
// Bench for periph_io_controller: directed scenarios plus randomized bus traffic
// compared against a register-level behavioural model.
module tb_periph_io_controller;

    localparam logic [31:0] BASE = 32'hC000_0000;
    localparam int MD = 1;
    localparam logic [6:0] SEGTAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = BASE;
    logic        we = 1'b0, re = 1'b0;
    logic [31:0] wdata = '0;
    logic [9:0]  switches = '0;
    logic        button = 1'b0, button4 = 1'b0;
    logic [31:0] rdata, rdata4;
    logic        rvalid, rvalid4, irq, irq4;
    logic [9:0]  leds, leds4;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [6:0]  d4h0, d4h1, d4h2, d4h3, d4h4, d4h5;
    logic [6:0]  hx [6];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign hx[0] = hex0; assign hx[1] = hex1; assign hx[2] = hex2;
    assign hx[3] = hex3; assign hx[4] = hex4; assign hx[5] = hex5;

    periph_io_controller #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(MD)) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .re(re), .wdata(wdata),
        .rdata(rdata), .rvalid(rvalid), .irq(irq), .switches(switches), .button(button),
        .leds(leds), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5));

    periph_io_controller #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .re(re), .wdata(wdata),
        .rdata(rdata4), .rvalid(rvalid4), .irq(irq4), .switches(switches), .button(button4),
        .leds(leds4), .hex0(d4h0), .hex1(d4h1), .hex2(d4h2), .hex3(d4h3), .hex4(d4h4), .hex5(d4h5));

    // Reference model: architectural registers plus input history queues.
    logic [9:0]  m_led, m_leds;
    logic [1:0]  m_ctrl;
    logic [23:0] m_hexval;
    logic [6:0]  m_seg [6];
    logic [6:0]  m_hex [6];
    bit          m_event, m_level, m_rvalid, m_irq;
    int          m_run;
    logic [31:0] m_rdata;
    bit          bq[$];
    logic [9:0]  swq[$];

    function automatic logic [31:0] model_read(int idx);
        if (idx == 0) return 32'(m_led);
        if (idx == 1) return 32'(swq[1]);
        if (idx == 2) return {30'd0, m_event, m_level};
        if (idx == 3) return 32'(m_ctrl);
        if (idx == 4) return 32'(m_hexval);
        if (idx >= 5 && idx <= 10) return 32'(m_seg[idx-5]);
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_led = '0; m_leds = '0; m_ctrl = '0; m_hexval = '0;
        for (int i = 0; i < 6; i++) begin m_seg[i] = 7'h7F; m_hex[i] = 7'h7F; end
        m_event = 0; m_level = 0; m_rvalid = 0; m_irq = 0; m_run = 0; m_rdata = '0;
        bq = {1'b0, 1'b0};
        swq = {10'd0, 10'd0};
    endtask

    // One clock edge for both the DUT and the model.
    task automatic step();
        bit sel, n_event, n_level, n_rvalid, n_irq, synced;
        int idx, n_run;
        logic [31:0] rv, n_rdata;
        logic [9:0] n_led, n_leds;
        logic [1:0] n_ctrl;
        logic [23:0] n_hexval;
        logic [6:0] n_seg [6];
        logic [6:0] n_hex [6];
        bit b_now;
        logic [9:0] sw_now;
        sel = (addr[31:6] == BASE[31:6]);
        idx = int'(addr[5:2]);
        synced = bq[1];
        rv = model_read(idx);
        n_leds = m_led;
        n_irq = m_ctrl[0] && m_event;
        for (int i = 0; i < 6; i++)
            n_hex[i] = m_ctrl[1] ? ~SEGTAB[m_hexval[4*i +: 4]] : m_seg[i];
        n_rvalid = sel && re;
        n_rdata = n_rvalid ? rv : m_rdata;
        n_level = m_level; n_run = 0;
        if (synced != m_level) begin
            n_run = m_run + 1;
            if (n_run >= MD) begin n_level = !m_level; n_run = 0; end
        end
        n_event = m_event; n_led = m_led; n_ctrl = m_ctrl; n_hexval = m_hexval; n_seg = m_seg;
        if (sel && we) begin
            if (idx == 0) n_led = wdata[9:0];
            if (idx == 2 && wdata[1]) n_event = 0;
            if (idx == 3) n_ctrl = wdata[1:0];
            if (idx == 4) n_hexval = wdata[23:0];
            if (idx >= 5 && idx <= 10) n_seg[idx-5] = wdata[6:0];
        end
        if (n_level && !m_level) n_event = 1;
        b_now = button; sw_now = switches;
        @(posedge clk); #1;
        m_led = n_led; m_leds = n_leds; m_ctrl = n_ctrl; m_hexval = n_hexval; m_seg = n_seg;
        m_hex = n_hex; m_event = n_event; m_level = n_level; m_run = n_run;
        m_rvalid = n_rvalid; m_rdata = n_rdata; m_irq = n_irq;
        bq.push_front(b_now); void'(bq.pop_back());
        swq.push_front(sw_now); void'(swq.pop_back());
    endtask

    task automatic drive(bit w, bit r, logic [31:0] a, logic [31:0] d);
        we = w; re = r; addr = a; wdata = d;
    endtask

    task automatic idle(int n);
        drive(0, 0, BASE, 0);
        repeat (n) step();
    endtask

    task automatic load(int idx);
        drive(0, 1, BASE + 32'(idx * 4), 0);
        step();
        drive(0, 0, BASE, 0);
    endtask

    task automatic store(int idx, logic [31:0] d);
        drive(1, 0, BASE + 32'(idx * 4), d);
        step();
        drive(0, 0, BASE, 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        drive(0, 0, BASE, 0);
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", rvalid); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
        checks++; if (leds !== 10'h0) begin errors++; $display("FAIL reset_leds got %h exp 0", leds); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (hx[i] !== 7'h7F) begin errors++; $display("FAIL reset_hex%0d got %h exp 7f", i, hx[i]); end
        end
    endtask

    task automatic test_switches();
        switches = 10'h3FF;
        idle(3);
        load(1);
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL sw_rvalid got %b exp 1", rvalid); end
        checks++; if (rdata !== 32'h3FF || rdata !== m_rdata) begin errors++; $display("FAIL sw_read1 got %h exp 3ff", rdata); end
        step();
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL sw_rvalid_drop got %b exp 0", rvalid); end
        switches = 10'h3BD;
        idle(3);
        load(1);
        checks++; if (rdata !== 32'h3BD) begin errors++; $display("FAIL sw_read2 got %h exp 3bd", rdata); end
    endtask

    task automatic test_led();
        store(0, 32'h155);
        checks++; if (leds !== 10'h0) begin errors++; $display("FAIL led_early got %h exp 0", leds); end
        idle(1);
        checks++; if (leds !== 10'h155) begin errors++; $display("FAIL led_write got %h exp 155", leds); end
        drive(1, 1, BASE + 32'h40, 32'h0);
        step();
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL outside_rvalid got %b exp 0", rvalid); end
        idle(2);
        checks++; if (leds !== 10'h155) begin errors++; $display("FAIL outside_led got %h exp 155", leds); end
    endtask

    task automatic test_button();
        button = 1'b1; step(); button = 1'b0;
        idle(2);
        load(2);
        checks++; if (rdata !== 32'h3) begin errors++; $display("FAIL btn_pressed got %h exp 3", rdata); end
        idle(2);
        load(2);
        checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL btn_released got %h exp 2", rdata); end
        store(2, 32'h0);
        load(2);
        checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL btn_w0 got %h exp 2", rdata); end
        store(2, 32'h2);
        load(2);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL btn_w1c got %h exp 0", rdata); end
        button4 = 1'b1; idle(2); button4 = 1'b0;
        idle(6);
        load(2);
        checks++; if (rdata4 !== 32'h0) begin errors++; $display("FAIL db4_short got %h exp 0", rdata4); end
        button4 = 1'b1; idle(4); button4 = 1'b0;
        idle(6);
        load(2);
        checks++; if (rdata4 !== 32'h2 || rvalid4 !== 1'b1) begin errors++; $display("FAIL db4_long got %h exp 2", rdata4); end
    endtask

    task automatic test_irq();
        store(3, 32'h1);
        button = 1'b1; step(); button = 1'b0;
        idle(4);
        checks++; if (irq !== 1'b1 || irq !== m_irq) begin errors++; $display("FAIL irq_set got %b exp 1", irq); end
        idle(2);
        button = 1'b1; step(); button = 1'b0;
        step();
        store(2, 32'h2);
        idle(1);
        load(2);
        checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL w1c_collision got %h exp 2", rdata); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_collision got %b exp 1", irq); end
        store(2, 32'h2);
        idle(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", irq); end
    endtask

    task automatic test_hex();
        logic [6:0] exp_hex [6];
        exp_hex = '{7'h40, 7'h0E, 7'h79, 7'h08, 7'h40, 7'h40};
        store(3, 32'h2);
        store(4, 32'h00A1F0);
        idle(1);
        for (int i = 0; i < 6; i++) begin
            checks++; if (hx[i] !== exp_hex[i]) begin errors++; $display("FAIL hexmode_hex%0d got %h exp %h", i, hx[i], exp_hex[i]); end
        end
        store(3, 32'h0);
        idle(1);
        for (int i = 0; i < 6; i++) begin
            checks++; if (hx[i] !== 7'h7F) begin errors++; $display("FAIL segmode_hex%0d got %h exp 7f", i, hx[i]); end
        end
    endtask

    task automatic test_collision();
        drive(1, 1, BASE, 32'h0AA);
        step();
        drive(0, 0, BASE, 0);
        checks++; if (rvalid !== 1'b1 || rdata !== 32'h155) begin errors++; $display("FAIL rw_same_rdata got %h exp 155", rdata); end
        idle(1);
        checks++; if (leds !== 10'h0AA) begin errors++; $display("FAIL rw_same_leds got %h exp 0aa", leds); end
    endtask

    task automatic test_reset_mid();
        store(3, 32'h3);
        store(2, 32'h0);
        drive(0, 1, BASE + 32'h4, 0);
        step();
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL mid_rvalid_pre got %b exp 1", rvalid); end
        #2 reset = 1'b1;
        model_reset();
        #1;
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid got %b exp 0", rvalid); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mid_rdata got %h exp 0", rdata); end
        checks++; if (leds !== 10'h0) begin errors++; $display("FAIL mid_leds got %h exp 0", leds); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq got %b exp 0", irq); end
        checks++; if (hex0 !== 7'h7F) begin errors++; $display("FAIL mid_hex0 got %h exp 7f", hex0); end
        drive(0, 0, BASE, 0);
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        #4;
    endtask

    task automatic test_random();
        int idx;
        for (int n = 0; n < 400; n++) begin
            idx = int'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0)
                drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, BASE + 32'h40 + 32'(idx * 4), $urandom);
            else
                drive($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, BASE + 32'(idx * 4), $urandom);
            if ($urandom_range(0, 3) == 0) button = ~button;
            if ($urandom_range(0, 7) == 0) switches = 10'($urandom);
            step();
            checks++; if (rvalid !== m_rvalid) begin errors++; $display("FAIL rnd%0d_rvalid got %b exp %b", n, rvalid, m_rvalid); end
            if (m_rvalid) begin
                checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rnd%0d_rdata got %h exp %h", n, rdata, m_rdata); end
            end
            checks++; if (leds !== m_leds) begin errors++; $display("FAIL rnd%0d_leds got %h exp %h", n, leds, m_leds); end
            checks++; if (irq !== m_irq) begin errors++; $display("FAIL rnd%0d_irq got %b exp %b", n, irq, m_irq); end
            for (int i = 0; i < 6; i++) begin
                checks++; if (hx[i] !== m_hex[i]) begin errors++; $display("FAIL rnd%0d_hex%0d got %h exp %h", n, i, hx[i], m_hex[i]); end
            end
        end
        drive(0, 0, BASE, 0);
    endtask

    initial begin
        test_reset();
        test_switches();
        test_led();
        test_button();
        test_irq();
        test_hex();
        test_collision();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/periph_io_controller.md
Name: periph_io_controller

Overview:
Memory-mapped controller between the pipeline's data-memory port and the board I/O: 10 switches, 1 push-button, 10 LEDs and six 7-segment displays. It synchronises and debounces the inputs and latches button-press events. It holds the LED and display registers and serves single-cycle-issue, one-cycle-latency load/store accesses in its address window. The board top instantiates it; the pad inversion of reset and button happens in the top, so every signal here is active-high.

Parameters:
BASE_ADDR, 32'hC000_0000, word-aligned base of the 64-byte register window.
DEBOUNCE_CYCLES, 1, consecutive synchronised cycles a new button level must persist before it is accepted (range 1..65535).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
addr  in  32  byte address from the data-memory stage
we  in  1  store strobe
re  in  1  load strobe
wdata  in  32  store data
rdata  out  32  load data, registered
rvalid  out  1  high one cycle after an accepted load
irq  out  1  button-event interrupt
switches  in  10  raw board switches
button  in  1  raw push-button, active-high (already inverted in the top)
leds  out  10  LED drive
hex0..hex5  out  7 each  segment drive, active-low (7'h7F = blank)

Behaviour:
- Select: sel = (addr[31:6] == BASE_ADDR[31:6]). Accesses with sel low are ignored: no write, no rvalid.
- Register map (addr[5:2]):
  - 0 LED, R/W [9:0]
  - 1 SWITCH, RO [9:0]
  - 2 BTN, bit0 debounced level RO, bit1 event sticky W1C
  - 3 CTRL, R/W: bit0 irq_en, bit1 hex_mode
  - 4 HEXVAL, R/W [23:0], nibble n drives hex n
  - 5..10 SEG0..SEG5, R/W [6:0]
  - 11..15 read 0, writes ignored
- Unused read bits return 0.
- Reset (async): LED, CTRL, HEXVAL = 0; SEG0..5 = 7'h7F; event = 0; debounced level = 0; counter = 0; sync flops = 0; rdata = 0; rvalid = 0; irq = 0; leds = 0; hex0..5 = 7'h7F.
- Store: we & sel at edge k updates the register at edge k. leds and hex outputs are registered and reflect the new value after edge k+1. Byte enables are not supported; stores are full-word.
- Load: re & sel at edge k captures rdata and sets rvalid at edge k; rvalid drops the next cycle unless re & sel is asserted again. Back-to-back loads are allowed, one per cycle.
- Load and store in the same cycle at the same address: the store is performed and rdata returns the pre-store value.
- Switches: 2-flop synchroniser, so SWITCH reflects the pins 2 cycles later.
- Button: 2-flop synchroniser, then debounce counter.
  - Counter resets to 0 whenever the synchronised value equals the current level.
  - Otherwise the counter increments; on reaching DEBOUNCE_CYCLES the level toggles and the counter clears.
  - A 0->1 transition of the level sets event on the same edge.
- Event set and W1C clear in the same cycle: set wins. Writing 0 to bit1 has no effect.
- irq = registered (irq_en & event); it follows changes one cycle later.
- Display: hex_mode = 0 drives hexN = SEGN. hex_mode = 1 drives hexN = ~dec(HEXVAL[4N+3:4N]).
  - dec is the standard 0-F gfedcba table, e.g. 0 -> 7'h3F, 1 -> 7'h06, A -> 7'h77, F -> 7'h71.
  - Switching mode changes the outputs one cycle later.
- Reset asserted mid-access: all state clears immediately; the pending rvalid is dropped.

Test Plan:
1. Reset, then load SWITCH with switches = 10'h3FF held -> rvalid after 1 cycle, rdata = 32'h3FF. Change switches to 10'h3BD, wait 3 cycles, load -> 32'h3BD.
2. Store 32'h155 to LED (BASE+0x00) -> leds = 10'h155 two edges after the store. Store to BASE+0x40 (outside window) -> leds unchanged, no rvalid.
3. DEBOUNCE_CYCLES = 1: button high for 1 cycle -> BTN reads 32'h3 then 32'h2 after release. Store 32'h2 to BTN -> reads 32'h0. DEBOUNCE_CYCLES = 4 with a 2-cycle pulse -> event stays 0.
4. CTRL = 1, button press -> irq = 1. W1C issued in the same cycle as a new debounced rising edge -> event remains 1, irq stays 1.
5. CTRL = 2, HEXVAL = 32'h00A1F0 -> hex0..hex5 = 7'h40, 7'h0E, 7'h79, 7'h08, 7'h40, 7'h40. CTRL = 0 -> hex0..5 = 7'h7F.
6. Load and store to LED in the same cycle (old 10'h155, new 10'h0AA) -> rdata = 32'h155, leds = 10'h0AA. Assert reset during an outstanding load -> rvalid = 0, all outputs at reset values.
